// File: rtl/apb_bridge_pkg.sv
// Shared types, constants and width helpers for the APB slave bridge.
package apb_bridge_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} bridge_state_t;

  typedef logic [2:0] err_cause_t;
  localparam err_cause_t ERR_NONE    = 3'd0;
  localparam err_cause_t ERR_ALIGN   = 3'd1;
  localparam err_cause_t ERR_RDSTRB  = 3'd2;
  localparam err_cause_t ERR_TIMEOUT = 3'd3;
  localparam err_cause_t ERR_SLAVE   = 3'd4;

  function automatic int unsigned strb_width(input int unsigned data_w);
    return data_w / 8;
  endfunction

  function automatic int unsigned align_bits(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

  // Counter must hold TIMEOUT itself so it can saturate there; keep at least one bit.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/apb_slave_bridge_if.sv
// APB completer port plus internal request/response bus of the bridge.
interface apb_slave_bridge_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [STRB_W-1:0] pstrb;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  logic              req_valid;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [STRB_W-1:0] req_strb;
  logic              rsp_ack;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  // Bridge view: completes APB, issues internal requests.
  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    input  rsp_ack, rsp_rdata, rsp_err,
    output prdata, pready, pslverr,
    output req_valid, req_write, req_addr, req_wdata, req_strb
  );

  // Environment view: APB requester and register-file responder.
  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    output rsp_ack, rsp_rdata, rsp_err,
    input  prdata, pready, pslverr,
    input  req_valid, req_write, req_addr, req_wdata, req_strb
  );

endinterface

// File: rtl/apb_bridge_timeout.sv
// Saturating response-wait counter; expired_c flags the last allowed wait cycle.
module apb_bridge_timeout
  import apb_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired_c
);
  localparam int unsigned CNT_W = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST  = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en && (count_q != LIMIT)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign expired_c = (TIMEOUT != 0) && en && (count_q == LAST);

endmodule

// File: rtl/apb_slave_bridge.sv
// APB4 completer bridging one APB port onto the single-request internal register bus.
module apb_slave_bridge
  import apb_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input logic               clk,
  input logic               rst,
  apb_slave_bridge_if.slave bus
);
  localparam int unsigned STRB_W = strb_width(DATA_W);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((1 << align_bits(DATA_W)) - 1);

  bridge_state_t     state_q, state_d;
  err_cause_t        cause_q, cause_d;
  logic              req_valid_q, req_valid_d;
  logic              req_write_q, req_write_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
  logic [STRB_W-1:0] req_strb_q, req_strb_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;
  logic              pready_q, pready_d;
  logic              pslverr_q, pslverr_d;

  logic setup_c;
  logic misalign_c;
  logic rdstrb_c;
  logic expired_c;

  assign setup_c    = bus.psel && !bus.penable;
  assign misalign_c = (bus.paddr & ALIGN_MASK) != '0;
  assign rdstrb_c   = !bus.pwrite && (bus.pstrb != '0);

  apb_bridge_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .clr       (state_q == REQ),
    .en        (state_q == WAIT),
    .expired_c (expired_c)
  );

  // Next state; APB outputs are loaded on entry to RESP and cleared otherwise.
  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    req_valid_d = 1'b0;
    req_write_d = req_write_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_strb_d  = req_strb_q;
    prdata_d    = '0;

    case (state_q)
      IDLE: begin
        if (setup_c) begin
          req_write_d = bus.pwrite;
          req_addr_d  = bus.paddr;
          req_wdata_d = bus.pwdata;
          req_strb_d  = bus.pwrite ? bus.pstrb : '1;
          if (misalign_c) begin
            cause_d = ERR_ALIGN;
            state_d = RESP;
          end else if (rdstrb_c) begin
            cause_d = ERR_RDSTRB;
            state_d = RESP;
          end else begin
            cause_d     = ERR_NONE;
            req_valid_d = 1'b1;
            state_d     = REQ;
          end
        end
      end
      REQ, WAIT: begin
        // Abort beats everything; a real ack beats a coincident timeout.
        if (!bus.psel) begin
          state_d = IDLE;
        end else if (bus.rsp_ack) begin
          cause_d  = bus.rsp_err ? ERR_SLAVE : ERR_NONE;
          prdata_d = req_write_q ? '0 : bus.rsp_rdata;
          state_d  = RESP;
        end else if ((state_q == WAIT) && expired_c) begin
          cause_d = ERR_TIMEOUT;
          state_d = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    pready_d  = (state_d == RESP);
    pslverr_d = (state_d == RESP) && (cause_d != ERR_NONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cause_q     <= ERR_NONE;
      req_valid_q <= 1'b0;
      req_write_q <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_strb_q  <= '0;
      prdata_q    <= '0;
      pready_q    <= 1'b0;
      pslverr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cause_q     <= cause_d;
      req_valid_q <= req_valid_d;
      req_write_q <= req_write_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_strb_q  <= req_strb_d;
      prdata_q    <= prdata_d;
      pready_q    <= pready_d;
      pslverr_q   <= pslverr_d;
    end
  end

  assign bus.req_valid = req_valid_q;
  assign bus.req_write = req_write_q;
  assign bus.req_addr  = req_addr_q;
  assign bus.req_wdata = req_wdata_q;
  assign bus.req_strb  = req_strb_q;
  assign bus.prdata    = prdata_q;
  assign bus.pready    = pready_q;
  assign bus.pslverr   = pslverr_q;

endmodule

// File: tb/tb_apb_slave_bridge.sv
// Scoreboard bench: APB requester, register-file responder and a monitor checking against a memory model.
module tb_apb_slave_bridge;
  localparam int TIMEOUT = 4;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } req_t;

  typedef struct {
    logic [31:0] prdata;
    bit          err;
    int          cyc;
  } rsp_t;

  typedef struct {
    int d;
    bit err;
  } cfg_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   stray_cnt = 0;
  int   stray_done = 0;

  req_t req_q[$];
  rsp_t rsp_q[$];
  cfg_t cfg_q[$];
  logic [31:0] model_mem [logic [31:0]];
  logic [31:0] periph_mem [logic [31:0]];

  apb_slave_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  apb_slave_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] st);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (st[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : 32'h0;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Register-file responder: acks d cycles after the request cycle (d<0: never).
  initial begin
    int          pend;
    bit          p_wr, p_err;
    logic [31:0] p_addr, p_wdata, cur;
    logic [3:0]  p_strb;
    cfg_t        cf;
    pend = -1;
    p_wr = 0; p_err = 0; p_addr = 0; p_wdata = 0; p_strb = 0;
    periph_mem[32'h24] = 32'h1234_5678;
    bus.rsp_ack = 1'b0; bus.rsp_err = 1'b0; bus.rsp_rdata = '0;
    forever begin
      @(negedge clk);
      bus.rsp_ack = 1'b0; bus.rsp_err = 1'b0; bus.rsp_rdata = '0;
      if (!rst) begin
        pend = -1;
      end else begin
        if (bus.req_valid) begin
          if (cfg_q.size() > 0) cf = cfg_q.pop_front();
          else cf = '{-1, 1'b0};
          pend = cf.d; p_err = cf.err;
          p_wr = bus.req_write; p_addr = bus.req_addr;
          p_wdata = bus.req_wdata; p_strb = bus.req_strb;
        end
        if (pend == 0) begin
          cur = periph_mem.exists(p_addr) ? periph_mem[p_addr] : 32'h0;
          bus.rsp_ack = 1'b1;
          bus.rsp_err = p_err;
          bus.rsp_rdata = p_wr ? $urandom : cur;
          if (p_wr && !p_err) periph_mem[p_addr] = merge(cur, p_wdata, p_strb);
          pend = -1;
        end else if (pend > 0) begin
          pend--;
        end else if (stray_cnt != stray_done) begin
          bus.rsp_ack = 1'b1;
          bus.rsp_rdata = $urandom;
          stray_done++;
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT issues a request or completes a transfer.
  initial begin
    req_t er;
    rsp_t ep;
    forever begin
      @(negedge clk);
      if (bus.req_valid) begin
        if (req_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL req_unexpected: got req_valid=1 required 0");
        end else begin
          er = req_q.pop_front();
          chk("req_write", 64'(bus.req_write), 64'(er.wr));
          chk("req_addr",  64'(bus.req_addr),  64'(er.addr));
          chk("req_wdata", 64'(bus.req_wdata), 64'(er.wdata));
          chk("req_strb",  64'(bus.req_strb),  64'(er.strb));
        end
      end
      if (bus.pready) begin
        if (rsp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL pready_unexpected: got pready=1 required 0 at cycle %0d", cyc);
        end else begin
          ep = rsp_q.pop_front();
          chk("prdata",  64'(bus.prdata),  64'(ep.prdata));
          chk("pslverr", 64'(bus.pslverr), 64'(ep.err));
          chk("pready_cycle", 64'(cyc), 64'(ep.cyc));
        end
      end else begin
        chk("idle_outputs", 64'({bus.pslverr, bus.prdata}), 64'h0);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.psel = 1'b0; bus.penable = 1'b0;
    end
  endtask

  // One APB transfer; abort_at>=0 drops psel after that many access cycles.
  task automatic apb_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input int d, input bit err, input int abort_at);
    bit   bad;
    rsp_t e;
    int   n;
    @(negedge clk);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr;
    bus.paddr = addr; bus.pwdata = wdata; bus.pstrb = strb;
    bad = (addr[1:0] != 2'b00) || (!wr && strb != 4'h0);
    if (!bad) begin
      req_q.push_back('{wr, addr, wdata, (wr ? strb : 4'hF)});
      cfg_q.push_back('{d, err});
    end
    if (bad) begin
      e = '{32'h0, 1'b1, cyc + 1};
      rsp_q.push_back(e);
    end else if (abort_at < 0) begin
      if (d >= 0 && d <= TIMEOUT) begin
        e = '{(wr ? 32'h0 : model_rd(addr)), err, cyc + 2 + d};
        if (wr && !err) model_mem[addr] = merge(model_rd(addr), wdata, strb);
      end else begin
        e = '{32'h0, 1'b1, cyc + 2 + TIMEOUT};
      end
      rsp_q.push_back(e);
    end
    @(negedge clk);
    bus.penable = 1'b1;
    if (abort_at >= 0 && !bad) begin
      repeat (abort_at) @(negedge clk);
      bus.psel = 1'b0; bus.penable = 1'b0;
    end else begin
      n = 0;
      while (!bus.pready && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (!bus.pready) begin
        checks++; errors++;
        $display("FAIL pready_wait: got no pready within %0d cycles required pready=1", n);
      end
    end
  endtask

  initial begin
    bit          wr, err;
    logic [31:0] addr, wdata;
    logic [3:0]  strb;
    int          d, ab;

    rst = 1'b0;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = '0; bus.pwdata = '0; bus.pstrb = '0;
    model_mem[32'h24] = 32'h1234_5678;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", 64'({bus.prdata, bus.pready, bus.pslverr, bus.req_valid,
                          bus.req_write, bus.req_strb}), 64'h0);
    chk("reset_addr_data", {bus.req_addr, bus.req_wdata}, 64'h0);
    rst = 1'b1;
    idle(2);

    apb_xfer(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, -1);
    idle(1);
    apb_xfer(1'b0, 32'h24, 32'h0, 4'h0, 3, 1'b0, -1);
    idle(1);
    apb_xfer(1'b0, 32'h02, 32'h0, 4'h0, 0, 1'b0, -1);
    idle(1);
    apb_xfer(1'b1, 32'h30, 32'hCAFE_F00D, 4'hF, -1, 1'b0, -1);
    idle(1);
    stray_cnt++;
    idle(3);
    apb_xfer(1'b0, 32'h10, 32'h0, 4'h0, 1, 1'b1, -1);
    apb_xfer(1'b1, 32'h14, 32'h0BAD_F00D, 4'h5, 0, 1'b0, -1);
    apb_xfer(1'b0, 32'h14, 32'h0, 4'h0, 2, 1'b0, -1);
    idle(1);

    // Reset while waiting for an ack abandons the transfer.
    @(negedge clk);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = 32'h20; bus.pwdata = '0; bus.pstrb = '0;
    req_q.push_back('{1'b0, 32'h20, 32'h0, 4'hF});
    cfg_q.push_back('{-1, 1'b0});
    @(negedge clk);
    bus.penable = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_ctrl", 64'({bus.prdata, bus.pready, bus.pslverr, bus.req_valid,
                              bus.req_write, bus.req_strb}), 64'h0);
    chk("async_rst_addr_data", {bus.req_addr, bus.req_wdata}, 64'h0);
    bus.psel = 1'b0; bus.penable = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    idle(1);
    apb_xfer(1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b0, -1);
    idle(1);

    for (int i = 0; i < 40; i++) begin
      wr    = 1'($urandom_range(0, 1));
      addr  = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      if ($urandom_range(0, 7) == 0) addr[1:0] = 2'($urandom_range(1, 3));
      wdata = $urandom;
      if (wr) strb = 4'($urandom);
      else strb = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      d   = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, TIMEOUT + 2));
      if (wr && d > TIMEOUT) d = -1;
      err = ($urandom_range(0, 5) == 0);
      ab  = -1;
      if ($urandom_range(0, 9) == 0) begin
        wr = 1'b0; addr[1:0] = 2'b00; strb = 4'h0;
        ab = int'($urandom_range(0, TIMEOUT - 1));
        d  = ($urandom_range(0, 1) == 1) ? -1 : ab + int'($urandom_range(1, 3));
      end
      apb_xfer(wr, addr, wdata, strb, d, err, ab);
      if (ab >= 0 || $urandom_range(0, 2) == 0) idle(4);
    end

    idle(6);
    chk("rsp_queue_drained", 64'(rsp_q.size()), 64'h0);
    chk("req_queue_drained", 64'(req_q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_slave_bridge.md
Name: apb_slave_bridge

Overview:
Parametrised APB4 completer that bridges one APB port onto the single-request internal register bus (request pulse, then ack/data/err response).
- Generalises the fixed 32-bit, single-cycle slave with configurable address/data width, byte strobes, wait-state insertion, response timeout, and protocol/alignment error checks.
- Sits between the system APB interconnect and a peripheral register file, for example the SPI register block.

Parameters:
ADDR_W, 32, APB/internal address width (≥ 4).
DATA_W, 32, data width; legal values 8, 16, 32, 64.
TIMEOUT, 16, max cycles to wait for ack after request; 0 disables the timeout.
STRB_W, DATA_W/8, derived; not to be overridden.

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low
psel  in  1  APB select
penable  in  1  APB access phase
pwrite  in  1  1 = write
paddr  in  ADDR_W  APB address
pwdata  in  DATA_W  APB write data
pstrb  in  STRB_W  APB write byte strobes
prdata  out  DATA_W  read data, registered
pready  out  1  transfer complete, registered
pslverr  out  1  transfer error; valid only while pready=1
req_valid  out  1  one-cycle internal request pulse
req_write  out  1  request direction
req_addr  out  ADDR_W  request address
req_wdata  out  DATA_W  request write data
req_strb  out  STRB_W  request strobes; all-ones on reads
rsp_ack  in  1  internal response valid; single cycle
rsp_rdata  in  DATA_W  internal read data, valid with rsp_ack
rsp_err  in  1  internal decode/access error, valid with rsp_ack

Behaviour:
- Reset (rst=0, async):
  - All outputs are 0; FSM goes to IDLE; timeout counter cleared.
  - Reset mid-transfer abandons the transfer with no response.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - Setup phase is detected as psel=1 && penable=0.
  - On setup: latch paddr, pwdata, pwrite, and strobes (pstrb for writes, all-ones for reads).
  - Check the latched transfer:
    - Misaligned: paddr[$clog2(STRB_W)-1:0] != 0.
    - Illegal read: pwrite=0 && pstrb != 0.
  - Check failure: go to RESP with error=1; no internal request is issued.
  - Otherwise: go to REQ.
- REQ (one cycle):
  - req_valid=1 with the latched fields.
  - Counter cleared.
  - Go to WAIT, or straight to RESP if rsp_ack=1 this cycle.
- WAIT:
  - Counter increments every cycle.
  - rsp_ack=1: latch rsp_rdata (reads only; writes return prdata=0) and rsp_err, then go to RESP.
  - Timeout: counter reaches TIMEOUT−1 with TIMEOUT≠0 → RESP with error=1 and prdata=0.
  - rsp_ack in the same cycle as the timeout wins; the response is used.
- RESP (one cycle):
  - pready=1; pslverr=error; prdata valid.
  - Next cycle: pready=0, prdata=0, pslverr=0; go to IDLE.
- req_* fields hold their value after req_valid until the next request; only req_valid is a pulse.
- Latency: with setup at T0 and ack in the REQ cycle T1, pready=1 at T2. Each extra ack cycle adds one wait state.
- Master abort: psel=0 in REQ/WAIT → return to IDLE. No pready is generated and any late rsp_ack is discarded.
- rsp_ack in IDLE or RESP is ignored.
- Back-to-back: a new setup phase may be sampled in the cycle after RESP.
- Only one request is ever outstanding.
- Counter width: $clog2(TIMEOUT+1); saturates and never wraps.

Decomposition:
- Package apb_bridge_pkg holds:
  - typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} bridge_state_t.
  - localparam function for STRB_W / alignment bit count.
  - Error-cause constants ERR_NONE, ERR_ALIGN, ERR_RDSTRB, ERR_TIMEOUT, ERR_SLAVE; used for debug/coverage only.
- One sub-module, apb_bridge_timeout: a parametrised saturating counter with clear, enable, and expired outputs.

Test Plan:
1. Write paddr=0x10, pwdata=0xDEADBEEF, pstrb=0xF; ack in the REQ cycle → req_valid pulse with req_addr=0x10, req_wdata=0xDEADBEEF, req_strb=0xF; pready=1 at T2, pslverr=0.
2. Read paddr=0x24; ack after 3 wait cycles with rsp_rdata=0x12345678 → pready low for 4 access cycles, then prdata=0x12345678, pslverr=0.
3. Read paddr=0x02 (DATA_W=32) → no req_valid; pready=1 at T1 with pslverr=1.
4. Write with no ack, TIMEOUT=4 → pready=1, pslverr=1, prdata=0 after 4 WAIT cycles; a later stray rsp_ack is ignored.
5. Read with rsp_err=1 and ack → pslverr=1; then an immediate back-to-back write completes cleanly with pslverr=0.
6. Async reset asserted in WAIT → all outputs 0 immediately; after release, a read of 0x0 completes normally.
